// File: rtl/mod_n_ctrl_pkg.sv
// Shared types for the modulo-N sequencing controller: FSM state encoding and helpers.
package mod_n_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == RUN) || (s == HOLD);
    endfunction

endpackage

// File: rtl/mod_n_seq_ctrl_if.sv
// Configuration handshake, run controls and status of the modulo-N sequencing controller.
interface mod_n_seq_ctrl_if #(
    parameter int W      = 4,
    parameter int REPS_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [W-1:0]      cfg_last;
    logic [REPS_W-1:0] cfg_reps;
    logic              start;
    logic              pause;
    logic              abort;
    logic [W-1:0]      count;
    logic              wrap;
    logic [REPS_W-1:0] period;
    logic              busy;
    logic              done;

    modport master (
        output cfg_valid, cfg_last, cfg_reps, start, pause, abort,
        input  cfg_ready, count, wrap, period, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_last, cfg_reps, start, pause, abort,
        output cfg_ready, count, wrap, period, busy, done
    );
endinterface

// File: rtl/mod_n_core.sv
// Modulo counter: counts 0..last while enabled, flags the last->0 step with wrap.
module mod_n_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap  = en && (count_q == last);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mod_n_seq_ctrl.sv
// Modulo-N run sequencer: accepts a modulus/repeat configuration in IDLE, then runs
// the counter for reps periods (or forever when reps is 0) with pause and abort.
//
//   state | meaning
//   IDLE  | waiting; configuration accepted, start launches a run
//   RUN   | counter advancing once per cycle unless paused
//   HOLD  | paused; count and period frozen
//   DONE  | one-cycle completion pulse, then back to IDLE
module mod_n_seq_ctrl
    import mod_n_ctrl_pkg::*;
#(
    parameter int MAX_N  = 16,
    parameter int REPS_W = 8
) (
    input logic              clk,
    input logic              reset_n,
    mod_n_seq_ctrl_if.slave  bus
);

    localparam int W = $clog2(MAX_N);
    localparam logic [W-1:0] LAST_RST = W'(MAX_N - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      last_q, last_d;
    logic [REPS_W-1:0] reps_q, reps_d;
    logic [REPS_W-1:0] period_q, period_d;
    logic [REPS_W-1:0] period_inc;
    logic              cfg_hs;
    logic              core_en;
    logic              core_clr;
    logic              core_wrap;
    logic [W-1:0]      core_count;

    // Abort outranks pause, which outranks the advance.
    assign core_en  = (state_q == RUN) && !bus.abort && !bus.pause;
    assign core_clr = ((state_q == IDLE) && bus.start) || (is_busy(state_q) && bus.abort);

    mod_n_core #(.W(W)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (core_en),
        .clr     (core_clr),
        .last    (last_q),
        .count   (core_count),
        .wrap    (core_wrap)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        reps_d     = reps_q;
        period_d   = period_q;
        cfg_hs     = bus.cfg_valid && (state_q == IDLE);
        period_inc = period_q + REPS_W'(1);

        if (cfg_hs) begin
            last_d = bus.cfg_last;
            reps_d = bus.cfg_reps;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    period_d = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    period_d = '0;
                end else if (bus.pause) begin
                    state_d = HOLD;
                end else if (core_wrap) begin
                    period_d = period_inc;
                    if ((reps_q != '0) && (period_inc == reps_q)) begin
                        state_d = DONE;
                    end
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    period_d = '0;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            reps_q   <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            reps_q   <= reps_d;
            period_q <= period_d;
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.count     = core_count;
    assign bus.wrap      = core_wrap;
    assign bus.period    = period_q;
    assign bus.busy      = is_busy(state_q);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_mod_n_seq_ctrl.sv
// Self-checking bench for mod_n_seq_ctrl: tick-based reference model plus directed scenarios.
module tb_mod_n_seq_ctrl;

    localparam int MAX_N  = 16;
    localparam int REPS_W = 8;
    localparam int W      = 4;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    mod_n_seq_ctrl_if #(.W(W), .REPS_W(REPS_W)) bus ();

    mod_n_seq_ctrl #(.MAX_N(MAX_N), .REPS_W(REPS_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is described by the number of advances since start;
    // count and period follow from it by division against the modulus of that run.
    int m_ticks, m_mod, m_last, m_reps;
    bit m_run, m_hold, m_done;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run   <= 1'b0;
            m_hold  <= 1'b0;
            m_done  <= 1'b0;
            m_ticks <= 0;
            m_last  <= MAX_N - 1;
            m_reps  <= 0;
            m_mod   <= MAX_N;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_run && !m_hold) begin
            if (bus.cfg_valid) begin
                m_last <= int'(bus.cfg_last);
                m_reps <= int'(bus.cfg_reps);
            end
            if (bus.start) begin
                m_run   <= 1'b1;
                m_ticks <= 0;
                m_mod   <= (bus.cfg_valid ? int'(bus.cfg_last) : m_last) + 1;
            end
        end else if (bus.abort) begin
            m_run   <= 1'b0;
            m_hold  <= 1'b0;
            m_ticks <= 0;
        end else if (m_hold) begin
            if (!bus.pause) begin
                m_hold <= 1'b0;
                m_run  <= 1'b1;
            end
        end else if (bus.pause) begin
            m_run  <= 1'b0;
            m_hold <= 1'b1;
        end else begin
            m_ticks <= m_ticks + 1;
            if (m_reps != 0 && m_ticks + 1 == m_reps * m_mod) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_cfg_ready", int'(bus.cfg_ready), int'(!m_run && !m_hold && !m_done));
        chk("cmp_busy", int'(bus.busy), int'(m_run || m_hold));
        chk("cmp_done", int'(bus.done), int'(m_done));
        chk("cmp_count", int'(bus.count), m_ticks % m_mod);
        chk("cmp_period", int'(bus.period), (m_ticks / m_mod) % (1 << REPS_W));
        chk("cmp_wrap", int'(bus.wrap),
            int'(m_run && !bus.pause && !bus.abort && (m_ticks % m_mod == m_mod - 1)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int l, input int r);
        bus.cfg_valid = 1'b1;
        bus.cfg_last  = l[W-1:0];
        bus.cfg_reps  = r[REPS_W-1:0];
        cyc();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic run_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int exp_cnt [10];
        exp_cnt = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        tests = 0;
        fails = 0;
        reset_n       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = '0;
        bus.cfg_reps  = '0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
        repeat (2) cyc();
        chk("rst_ready", int'(bus.cfg_ready), 1);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        cyc();

        // last=4 reps=2: two periods, done in cycle 11 after start
        cfg(4, 2);
        run_start();
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) cyc();
            if (k <= 10) chk("r36_count", int'(bus.count), exp_cnt[k-1]);
            chk("r36_wrap", int'(bus.wrap), int'(k == 5 || k == 10));
            chk("r36_done", int'(bus.done), int'(k == 11));
        end
        chk("r36_period", int'(bus.period), 2);
        cyc();
        chk("r36_idle", int'(bus.cfg_ready), 1);

        // last=0 reps=3: wrap every cycle
        cfg(0, 3);
        run_start();
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) cyc();
            chk("r37_wrap", int'(bus.wrap), int'(k <= 3));
            chk("r37_done", int'(bus.done), int'(k == 4));
            chk("r37_count", int'(bus.count), 0);
        end
        cyc();

        // last=7 free-running, pause at 5
        cfg(7, 0);
        run_start();
        n = 0;
        while (bus.count != 4'd5 && n < 20) begin
            cyc();
            n++;
        end
        chk("r38_reach5", int'(bus.count), 5);
        bus.pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("r38_hold_count", int'(bus.count), 5);
            chk("r38_hold_wrap", int'(bus.wrap), 0);
        end
        bus.pause = 1'b0;
        cyc();
        chk("r38_resume", int'(bus.count), 5);
        cyc();
        chk("r38_six", int'(bus.count), 6);
        cyc();
        chk("r38_seven", int'(bus.count), 7);
        chk("r38_wrap7", int'(bus.wrap), 1);
        cyc();
        chk("r38_zero", int'(bus.count), 0);
        chk("r38_period", int'(bus.period), 1);
        run_start();
        do_abort();

        // last=9, abort at count 3 of period 1
        cfg(9, 0);
        run_start();
        n = 0;
        while (!(bus.period == 8'd1 && bus.count == 4'd3) && n < 40) begin
            cyc();
            n++;
        end
        chk("r39_reach", int'(bus.count) + 100 * int'(bus.period), 103);
        do_abort();
        chk("r39_busy", int'(bus.busy), 0);
        chk("r39_count", int'(bus.count), 0);
        chk("r39_period", int'(bus.period), 0);
        chk("r39_ready", int'(bus.cfg_ready), 1);
        chk("r39_done", int'(bus.done), 0);
        cyc();
        chk("r39_no_done", int'(bus.done), 0);
        do_abort();

        // config and start together, config during RUN refused
        bus.cfg_valid = 1'b1;
        bus.cfg_last  = 4'd2;
        bus.cfg_reps  = 8'd2;
        bus.start     = 1'b1;
        cyc();
        bus.start     = 1'b0;
        bus.cfg_last  = 4'd5;
        bus.cfg_reps  = 8'd7;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) cyc();
            if (k <= 6) chk("r40_count", int'(bus.count), (k - 1) % 3);
            chk("r40_done", int'(bus.done), int'(k == 7));
            if (k == 2) chk("r40_ready_run", int'(bus.cfg_ready), 0);
        end
        chk("r40_period", int'(bus.period), 2);
        bus.cfg_valid = 1'b0;
        cyc();
        run_start();
        cyc();
        cyc();
        chk("r40_keep_last", int'(bus.count), 2);
        chk("r40_keep_wrap", int'(bus.wrap), 1);
        n = 0;
        while (!bus.done && n < 10) begin
            cyc();
            n++;
        end
        chk("r40_done2", int'(bus.done), 1);
        cyc();

        // reset mid-run
        cfg(9, 0);
        run_start();
        n = 0;
        while (bus.count != 4'd6 && n < 20) begin
            cyc();
            n++;
        end
        reset_n = 1'b0;
        #1;
        chk("r41_count", int'(bus.count), 0);
        chk("r41_busy", int'(bus.busy), 0);
        chk("r41_wrap", int'(bus.wrap), 0);
        chk("r41_done", int'(bus.done), 0);
        chk("r41_ready", int'(bus.cfg_ready), 1);
        cyc();
        reset_n = 1'b1;
        cyc();
        run_start();
        for (int k = 2; k <= 17; k++) begin
            cyc();
            if (k == 16) chk("r41_last15", int'(bus.count), 15);
            if (k == 16) chk("r41_wrap15", int'(bus.wrap), 1);
            if (k == 17) chk("r41_period", int'(bus.period), 1);
        end
        do_abort();

        // free-running period wraps modulo 256
        cfg(0, 0);
        run_start();
        for (int k = 2; k <= 257; k++) begin
            cyc();
            if (k == 256) chk("fr_period_255", int'(bus.period), 255);
            if (k == 257) chk("fr_period_wrap", int'(bus.period), 0);
        end
        do_abort();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mod_n_seq_ctrl.md
MOD_N_SEQ_CTRL -- requirements
Module: mod_n_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_N, default 16, setting the largest supported modulus; W = $clog2(MAX_N).
REQ-002 The block SHALL have parameter REPS_W, default 8, setting the width of the period-repeat count.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration acceptance; high only in IDLE.
REQ-008 cfg_last  input  W  terminal count, i.e. modulus minus 1.
REQ-009 cfg_reps  input  REPS_W  periods to run; 0 means free-running.
REQ-010 start  input  1  single-cycle run request.
REQ-011 pause  input  1  level; freezes counting while high.
REQ-012 abort  input  1  single-cycle cancel.
REQ-013 count  output  W  current count value.
REQ-014 wrap  output  1  high in the cycle count advances from last_q to 0.
REQ-015 period  output  REPS_W  completed periods since start.
REQ-016 busy  output  1  high in RUN or HOLD.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, HOLD and DONE.
REQ-019 A handshake (cfg_valid & cfg_ready) SHALL latch cfg_last into last_q and cfg_reps into reps_q; no configuration is accepted outside IDLE.
REQ-020 start in IDLE SHALL move to RUN next cycle with count=0 and period=0; if a handshake occurs in the same cycle, the new configuration SHALL be used.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 In RUN with pause=0, count SHALL increment by 1 per cycle; at count==last_q it SHALL return to 0, wrap SHALL be 1 that cycle, and period SHALL increment.
REQ-023 With last_q=0, count SHALL stay 0 and wrap SHALL assert every RUN cycle.
REQ-024 With reps_q!=0, a wrap where period+1==reps_q SHALL move to DONE, with count=0 and period=reps_q.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 With reps_q=0, the block SHALL run until abort, and period SHALL wrap modulo 2^REPS_W.
REQ-027 pause=1 in RUN SHALL block the advance that cycle and move to HOLD; in HOLD, count and period SHALL be frozen and wrap=0; pause=0 in HOLD SHALL return to RUN, resuming the advance next cycle.
REQ-028 Priority SHALL be abort > pause > advance.
REQ-029 abort in RUN or HOLD SHALL go to IDLE next cycle with count=0, period=0 and no done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-030 count SHALL never exceed last_q; last_q and reps_q SHALL be stable outside IDLE.

Reset
REQ-031 While reset_n=0, the block SHALL be in IDLE with count=0, period=0, wrap=0, busy=0, done=0, last_q=MAX_N-1 and reps_q=0.
REQ-032 cfg_ready SHALL decode from state, so it is 1 during and after reset.
REQ-033 Reset asserted mid-run SHALL take effect immediately, with no done pulse.

Structure
REQ-034 State encodings and the IDLE/RUN/HOLD/DONE constants SHALL live in shared package mod_n_ctrl_pkg.
REQ-035 A sub-module mod_n_core (inputs en, clr, last; outputs count, wrap) SHALL hold the counter; the FSM and period logic SHALL remain in mod_n_seq_ctrl.

Verification
REQ-036 Config last=4, reps=2, then start -> count 0,1,2,3,4,0,1,2,3,4; wrap on both 4s; done exactly 11 cycles after start; period=2.
REQ-037 last=0, reps=3 -> wrap high for 3 consecutive cycles, then done; count stays 0.
REQ-038 last=7, reps=0, pause at count=5 for 4 cycles -> count holds 5, wrap=0; after release, 6,7,0 with wrap on 7.
REQ-039 abort at count=3 of period 1 (last=9) -> next cycle IDLE, count=0, period=0, no done; cfg_ready=1.
REQ-040 cfg_valid and start in the same IDLE cycle (last=2) -> run uses modulus 3; cfg_valid during RUN is not accepted.
REQ-041 reset_n low at count=6 -> outputs 0 immediately; after release, state IDLE and last_q=MAX_N-1.
